uart_msg_gen: RTL

UART_MSG_GEN -- requirements
Module: uart_msg_gen

---
 rtl/uart_msg_gen.sv | 170 +++++++++++++++++
 1 files changed

// File: rtl/uart_msg_gen.sv
`default_nettype none
// +---------------------------------------------------------------------------+
// | uart_msg_gen: sends a buffered byte message to a UART, periodic/triggered |
// | Option macro: UART_MSG_CRLF_EN (append CR LF after the buffer bytes)      |
// | Revision: 1.0                                                             |
// +---------------------------------------------------------------------------+
module uart_msg_gen #(
  parameter int DEPTH    = 32,
  parameter int ADDR_W   = 5,
  parameter int PERIOD_W = 24
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                mode,
  input  logic                trig,
  input  logic [PERIOD_W-1:0] period,
  input  logic [ADDR_W:0]     msg_len,
  input  logic                ld_en,
  input  logic [ADDR_W-1:0]   ld_addr,
  input  logic [7:0]          ld_data,
  input  logic                tx_busy,
  output logic [7:0]          write_data,
  output logic                write_en,
  output logic                busy,
  output logic                done,
  output logic                overrun
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    SEND  = 2'd2,
    WAIT  = 2'd3
  } state_t;

  localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W+1)'(DEPTH);

  state_t               state_q, state_d;
  logic [PERIOD_W-1:0]  timer_q, timer_d;
  logic [ADDR_W:0]      idx_q, idx_d;
  logic [ADDR_W:0]      len_q, len_d;
  logic [7:0]           write_data_q, write_data_d;
  logic                 write_en_q, write_en_d;
  logic                 done_q, done_d;
  logic                 overrun_q, overrun_d;
  logic                 tx_busy_reg_q;
  logic [7:0]           rd_q;
  logic [7:0]           mem_q [DEPTH];

  logic                 timer_hit;
  logic                 start;
  logic                 tx_fall;
  logic [ADDR_W:0]      total;

  // Buffer kept reset-free so it maps onto block RAM; read registered in FETCH
  always_ff @(posedge clk) begin
    if (ld_en && state_q == IDLE) begin
      mem_q[ld_addr] <= ld_data;
    end
    if (state_q == FETCH) begin
      rd_q <= mem_q[idx_q[ADDR_W-1:0]];
    end
  end

  always_comb begin
    timer_hit = 1'b0;
    timer_d   = '0;
    if (!mode && period != '0) begin
      timer_hit = (timer_q == period - PERIOD_W'(1));
      timer_d   = (timer_q >= period - PERIOD_W'(1)) ? '0 : timer_q + PERIOD_W'(1);
    end
  end

  assign start   = timer_hit | (mode & trig);
  assign tx_fall = tx_busy_reg_q & ~tx_busy;

`ifdef UART_MSG_CRLF_EN
  assign total = len_q + (ADDR_W+1)'(2);
`else
  assign total = len_q;
`endif

  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    len_d        = len_q;
    write_data_d = write_data_q;
    write_en_d   = 1'b0;
    done_d       = 1'b0;
    overrun_d    = overrun_q;

    if (start && state_q != IDLE) begin
      overrun_d = 1'b1;
    end

    case (state_q)
      IDLE: begin
        if (start && msg_len != '0) begin
          len_d   = (msg_len > DEPTH_C) ? DEPTH_C : msg_len;
          idx_d   = '0;
          state_d = FETCH;
        end
      end
      FETCH: begin
        state_d = SEND;
      end
      SEND: begin
`ifdef UART_MSG_CRLF_EN
        if (idx_q == len_q) begin
          write_data_d = 8'h0D;
        end else if (idx_q == len_q + (ADDR_W+1)'(1)) begin
          write_data_d = 8'h0A;
        end else begin
          write_data_d = rd_q;
        end
`else
        write_data_d = rd_q;
`endif
        write_en_d = 1'b1;
        idx_d      = idx_q + (ADDR_W+1)'(1);
        state_d    = WAIT;
      end
      WAIT: begin
        if (tx_fall) begin
          if (idx_q >= total) begin
            state_d = IDLE;
            done_d  = 1'b1;
          end else begin
            state_d = FETCH;
          end
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      timer_q       <= '0;
      idx_q         <= '0;
      len_q         <= '0;
      write_data_q  <= 8'h00;
      write_en_q    <= 1'b0;
      done_q        <= 1'b0;
      overrun_q     <= 1'b0;
      tx_busy_reg_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      timer_q       <= timer_d;
      idx_q         <= idx_d;
      len_q         <= len_d;
      write_data_q  <= write_data_d;
      write_en_q    <= write_en_d;
      done_q        <= done_d;
      overrun_q     <= overrun_d;
      tx_busy_reg_q <= tx_busy;
    end
  end

  assign write_data = write_data_q;
  assign write_en   = write_en_q;
  assign busy       = (state_q != IDLE);
  assign done       = done_q;
  assign overrun    = overrun_q;

endmodule
`default_nettype wire
